step_sequencer: RTL



---
 rtl/step_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// Multi-step timing sequencer: start walks a step index through STEPS programmable-length steps.
// Optional run statistics (x, y) are built when STEP_SEQ_STATS_EN is defined.
module step_sequencer #(
  parameter int WIDTH  = 8,
  parameter int STEPS  = 4,
  parameter int STEP_W = $clog2(STEPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   loop,
  input  logic                   pause,
  input  logic                   abort,
  input  logic [STEPS*WIDTH-1:0] tc,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_W-1:0]      i,
  output logic [WIDTH-1:0]       c1,
  output logic [STEPS-1:0]       act,
  output logic [WIDTH-1:0]       x,
  output logic [WIDTH-1:0]       y
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             loop_r;
  logic [WIDTH-1:0] cur_tc;
  logic             step_end;
  logic             last;

  assign cur_tc   = tc[int'(i)*WIDTH +: WIDTH];
  assign step_end = (c1 == cur_tc);
  assign last     = (i == STEP_W'(STEPS-1));

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign act  = busy ? (STEPS'(1) << i) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      loop_r <= 1'b0;
      i      <= '0;
      c1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i      <= '0;
            c1     <= '0;
            loop_r <= loop;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (!pause) begin
            if (!step_end) begin
              c1 <= c1 + WIDTH'(1);
            end else begin
              c1 <= '0;
              if (!last)       i     <= i + STEP_W'(1);
              else if (loop_r) i     <= '0;
              else             state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STEP_SEQ_STATS_EN
  logic start_acc;
  logic run_adv;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;

  assign start_acc = (state == IDLE) && start;
  assign run_adv   = (state == RUN) && !abort && !pause;

  // x saturates, y wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (start_acc) begin
      x_q <= '0;
      y_q <= '0;
    end else if (run_adv) begin
      if (x_q != '1) x_q <= x_q + WIDTH'(1);
      if (step_end)  y_q <= y_q + WIDTH'(1);
    end
  end

  assign x = x_q;
  assign y = y_q;
`else
  assign x = '0;
  assign y = '0;
`endif

endmodule
